pet_key_injector: RTL and testbench

PET_KEY_INJECTOR -- requirements
Module: pet_key_injector

---
 rtl/pet_key_injector.sv | 241 ++++++++++++++++++++++++
 tb/tb_pet_key_injector.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pet_key_injector.sv
// -----------------------------------------------------------------------------
// pet_key_injector
//   Types key codes into a Commodore PET keyboard matrix. Codes are queued in a
//   small FIFO; a sequencer pops them one at a time. For each code it optionally
//   presses shift alone, then presses the key (plus shift), then releases
//   everything for a gap. The PIA row select (keyrow) is answered one cycle
//   later with active-low column bits.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   code[7:0]    in   [7]=shift, [6:3]=row, [2:0]=column
//   code_strobe  in   one-cycle FIFO write of code
//   suspend      in   freeze sequencer and timers (FIFO still accepts writes)
//   flush        in   empty FIFO, sequencer back to idle
//   keyrow[3:0]  in   row being scanned by the PIA
//   keyin[7:0]   out  active-low column bits for keyrow (registered)
//   busy         out  sequencer active or FIFO not empty
//   level        out  FIFO occupancy 0..DEPTH
//   overflow     out  sticky: a write was dropped on a full FIFO
//   bad_code     out  sticky: a popped code had row >= NROWS
// -----------------------------------------------------------------------------
module pet_key_injector #(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 2500000,
    parameter int GAP_CYCLES  = 1500000,
    parameter int SHIFT_LEAD  = 250000,
    parameter int NROWS       = 10,
    parameter int SHIFT_ROW   = 8,
    parameter int SHIFT_COL   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               code,
    input  logic                     code_strobe,
    input  logic                     suspend,
    input  logic                     flush,
    input  logic [3:0]               keyrow,
    output logic [7:0]               keyin,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     bad_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Timer only ever holds (parameter - 1), so clog2 of the largest is enough.
    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXP   = (MAX_HG > SHIFT_LEAD) ? MAX_HG : SHIFT_LEAD;
    localparam int TW     = (MAXP < 2) ? 1 : $clog2(MAXP);

    localparam logic [TW-1:0] T_HOLD  = TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [TW-1:0] T_GAP   = TW'((GAP_CYCLES  > 0) ? GAP_CYCLES  - 1 : 0);
    localparam logic [TW-1:0] T_SHIFT = TW'((SHIFT_LEAD  > 0) ? SHIFT_LEAD  - 1 : 0);
    localparam bit            HAS_SHIFT = (SHIFT_LEAD > 0);
    localparam bit            HAS_GAP   = (GAP_CYCLES > 0);

    localparam logic [3:0] SH_ROW = 4'(SHIFT_ROW);
    localparam logic [2:0] SH_COL = 3'(SHIFT_COL);
    localparam logic [4:0] ROWS   = 5'(NROWS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PRESS, S_GAP} state_t;

    // -------------------------------------------------------------------------
    // Reset release synchronizer: assertion is immediate, the design only
    // starts acting two clocks after reset_n rises.
    // -------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_run = r_rst_sync[1];

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic          r_overflow, r_bad_code;

    logic [7:0] w_head;
    logic       w_empty, w_full, w_pop, w_wr, w_ovf, w_head_bad;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [7:0]    r_key,   w_key_nxt;
    logic          w_bad_set;

    assign w_head     = r_mem[r_rptr];
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_head_bad = ({1'b0, w_head[6:3]} >= ROWS);

    // Pop only from idle; flush wins over everything.
    assign w_pop = w_run && !flush && !suspend && (r_state == S_IDLE) && !w_empty;
    // A full FIFO still accepts a write when the same cycle pops.
    assign w_wr  = w_run && !flush && code_strobe && (!w_full || w_pop);
    assign w_ovf = w_run && !flush && code_strobe && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= code;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_bad_code <= 1'b0;
        end else begin
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_wr)  r_wptr <= r_wptr + AW'(1);
                if (w_pop) r_rptr <= r_rptr + AW'(1);
                case ({w_wr, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
            end
            if (w_ovf)     r_overflow <= 1'b1;
            if (w_bad_set) r_bad_code <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_key   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_key   <= w_key_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_key_nxt   = r_key;
        w_bad_set   = 1'b0;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
        end else if (w_run && !suspend) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_head_bad) begin
                            // Discard and try the next entry on the next cycle.
                            w_bad_set = 1'b1;
                        end else begin
                            w_key_nxt = w_head;
                            if (w_head[7] && HAS_SHIFT) begin
                                w_state_nxt = S_SHIFT;
                                w_timer_nxt = T_SHIFT;
                            end else begin
                                w_state_nxt = S_PRESS;
                                w_timer_nxt = T_HOLD;
                            end
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_timer == '0) begin
                        w_state_nxt = S_PRESS;
                        w_timer_nxt = T_HOLD;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                S_PRESS: begin
                    if (r_timer == '0) begin
                        w_state_nxt = HAS_GAP ? S_GAP : S_IDLE;
                        w_timer_nxt = T_GAP;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                S_GAP: begin
                    if (r_timer == '0) begin
                        w_state_nxt = S_IDLE;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Matrix response: one cycle after keyrow is sampled.
    // -------------------------------------------------------------------------
    logic       w_shift_on, w_key_on;
    logic [7:0] w_keyin_nxt;
    logic [7:0] r_keyin;

    assign w_shift_on = (r_state == S_SHIFT) || ((r_state == S_PRESS) && r_key[7]);
    assign w_key_on   = (r_state == S_PRESS);

    always_comb begin
        w_keyin_nxt = 8'hFF;
        if ({1'b0, keyrow} < ROWS) begin
            // Both may clear bits in the same row; they simply combine.
            if (w_shift_on && (keyrow == SH_ROW)) w_keyin_nxt[SH_COL]     = 1'b0;
            if (w_key_on && (keyrow == r_key[6:3])) w_keyin_nxt[r_key[2:0]] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_keyin <= 8'hFF;
        else          r_keyin <= w_keyin_nxt;
    end

    assign keyin    = r_keyin;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign bad_code = r_bad_code;

endmodule

// File: tb/tb_pet_key_injector.sv
// -----------------------------------------------------------------------------
// tb_pet_key_injector
//   Directed bench for pet_key_injector with HOLD=4, GAP=3, SHIFT_LEAD=2,
//   DEPTH=4. Stimulus pushes the expected key episode (column pattern and run
//   length of each segment) into a queue; an independent monitor measures
//   every non-idle keyin episode and compares it against the queue head.
// -----------------------------------------------------------------------------
module tb_pet_key_injector;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] code;
    logic       code_strobe;
    logic       suspend;
    logic       flush;
    logic [3:0] keyrow;
    logic [7:0] keyin;
    logic       busy;
    logic [2:0] level;
    logic       overflow;
    logic       bad_code;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0]  v1;
        logic [15:0] n1;
        logic [7:0]  v2;
        logic [15:0] n2;
    } ep_t;

    ep_t exp_q[$];

    pet_key_injector #(
        .DEPTH(4), .HOLD_CYCLES(4), .GAP_CYCLES(3), .SHIFT_LEAD(2),
        .NROWS(10), .SHIFT_ROW(8), .SHIFT_COL(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .code(code), .code_strobe(code_strobe),
        .suspend(suspend), .flush(flush), .keyrow(keyrow), .keyin(keyin),
        .busy(busy), .level(level), .overflow(overflow), .bad_code(bad_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] v1, input int n1, input logic [7:0] v2, input int n2);
        ep_t e;
        e.v1 = v1; e.n1 = 16'(n1); e.v2 = v2; e.n2 = 16'(n2);
        exp_q.push_back(e);
    endtask

    task automatic strobe(input logic [7:0] c);
        @(negedge clk);
        code = c;
        code_strobe = 1'b1;
        @(negedge clk);
        code_strobe = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    // Monitor: measure each episode of keyin != FF as up to two segments.
    initial begin
        ep_t got, e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && keyin !== 8'hFF) begin
                got = '0;
                got.v1 = keyin;
                got.v2 = 8'hFF;
                while (keyin === got.v1 && got.n1 < 16'd100) begin
                    got.n1 = got.n1 + 16'd1;
                    @(negedge clk);
                end
                if (keyin !== 8'hFF) begin
                    got.v2 = keyin;
                    while (keyin === got.v2 && got.n2 < 16'd100) begin
                        got.n2 = got.n2 + 16'd1;
                        @(negedge clk);
                    end
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: got %h x%0d then %h x%0d, nothing queued",
                             got.v1, got.n1, got.v2, got.n2);
                end else begin
                    e = exp_q.pop_front();
                    chk("key_pattern", {48'd0, got.v1, got.v2}, {48'd0, e.v1, e.v2});
                    chk("key_lengths", {32'd0, got.n1, got.n2}, {32'd0, e.n1, e.n2});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        code = 8'h00;
        code_strobe = 1'b0;
        suspend = 1'b0;
        flush = 1'b0;
        keyrow = 4'd1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_keyin",    {56'd0, keyin}, 64'hFF);
        chk("rst_busy",     {63'd0, busy}, 64'd0);
        chk("rst_level",    {61'd0, level}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_bad_code", {63'd0, bad_code}, 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Case 1: plain key row1 col2
        keyrow = 4'd1;
        push_exp(8'hFB, 4, 8'hFF, 0);
        strobe(8'h0A);
        k = 0;
        while (keyin !== 8'hFB && k < 50) begin @(negedge clk); k++; end
        chk("c1_press_seen", {56'd0, keyin}, 64'hFB);
        k = 0;
        while (keyin === 8'hFB && k < 50) begin @(negedge clk); k++; end
        k = 1;
        while (busy === 1'b1 && k < 50) begin @(negedge clk); k++; end
        chk("c1_busy_drop", 64'(k), 64'd3);
        wait_idle("c1_idle");

        // Case 2: shifted key row8 col1, shares the shift row
        keyrow = 4'd8;
        push_exp(8'hFE, 2, 8'hFC, 4);
        strobe(8'hC1);
        wait_idle("c2_idle");

        // Case 6: full FIFO, strobe and pop in the same cycle
        keyrow = 4'd1;
        suspend = 1'b1;
        push_exp(8'hFE, 4, 8'hFF, 0); strobe(8'h08);
        push_exp(8'hFD, 4, 8'hFF, 0); strobe(8'h09);
        push_exp(8'hFB, 4, 8'hFF, 0); strobe(8'h0A);
        push_exp(8'hF7, 4, 8'hFF, 0); strobe(8'h0B);
        chk("c6_level_full", {61'd0, level}, 64'd4);
        chk("c6_ovf_before", {63'd0, overflow}, 64'd0);
        push_exp(8'hEF, 4, 8'hFF, 0);
        suspend = 1'b0;
        code = 8'h0C;
        code_strobe = 1'b1;
        @(negedge clk);
        code_strobe = 1'b0;
        chk("c6_level_same", {61'd0, level}, 64'd4);
        chk("c6_ovf_after", {63'd0, overflow}, 64'd0);
        wait_idle("c6_idle");

        // Case 3: five strobes while suspended, one lost
        suspend = 1'b1;
        push_exp(8'hFE, 4, 8'hFF, 0); strobe(8'h08);
        push_exp(8'hFD, 4, 8'hFF, 0); strobe(8'h09);
        push_exp(8'hFB, 4, 8'hFF, 0); strobe(8'h0A);
        push_exp(8'hF7, 4, 8'hFF, 0); strobe(8'h0B);
        strobe(8'h0C);
        chk("c3_level", {61'd0, level}, 64'd4);
        chk("c3_overflow", {63'd0, overflow}, 64'd1);
        suspend = 1'b0;
        wait_idle("c3_idle");

        // Flush beats a simultaneous strobe; sticky flag survives
        suspend = 1'b1;
        strobe(8'h09);
        strobe(8'h0A);
        flush = 1'b1;
        code = 8'h0B;
        code_strobe = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        code_strobe = 1'b0;
        chk("flush_level", {61'd0, level}, 64'd0);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_ovf_sticky", {63'd0, overflow}, 64'd1);
        suspend = 1'b0;
        repeat (10) @(negedge clk);

        // Case 4: bad row code, then a valid key one cycle later
        suspend = 1'b1;
        strobe(8'h78);
        push_exp(8'hFB, 4, 8'hFF, 0);
        strobe(8'h0A);
        chk("c4_bad_before", {63'd0, bad_code}, 64'd0);
        suspend = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (keyin !== 8'hFB && k < 20);
        chk("c4_latency", 64'(k), 64'd3);
        chk("c4_bad_code", {63'd0, bad_code}, 64'd1);
        wait_idle("c4_idle");

        // Case 5: reset during PRESS with another code still queued
        keyrow = 4'd1;
        push_exp(8'hFB, 3, 8'hFF, 0);
        strobe(8'h0A);
        strobe(8'h0B);
        k = 0;
        while (keyin !== 8'hFB && k < 50) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("c5_keyin_rst", {56'd0, keyin}, 64'hFF);
        chk("c5_level_rst", {61'd0, level}, 64'd0);
        chk("c5_busy_rst", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("c5_idle_after", {63'd0, busy}, 64'd0);
        push_exp(8'hFB, 4, 8'hFF, 0);
        strobe(8'h0A);
        wait_idle("c5_idle");

        repeat (5) @(negedge clk);
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
